tkr_asic_data_tx: RTL
=====================

# tkr_asic_data_tx

Serial transmitter that emulates one pCT tracker front-end ASIC data output. It sends one event packet per accepted Start: start bit, 11-bit header, then NClus 12-bit cluster words. The packets match what the front-end FPGA tracker receiver parses. It sits in the tracker test harness and self-test firmware, driving one ASIC data line into the receiver so the receive path can be exercised without silicon.

## Interface

Parameters:
- MAXCLUS, 10: largest accepted cluster count (legal range 0..14).
- GAP, 2: minimum idle zero bits after each packet (must be ≥1).

Ports:
- Clock  in  1  system clock; one serial bit per cycle.
- Reset  in  1  synchronous, active-high reset.
- ClusWr  in  1  write ClusData into the cluster RAM at ClusAddr; ignored while Busy.
- ClusAddr  in  4  cluster RAM address.
- ClusData  in  12  cluster word: [11:6] nStripM1, [5:0] first strip.
- Start  in  1  request to transmit one packet.
- Tag  in  2  trigger tag, sent as header bits [9:8].
- ChipErr  in  1  ASIC error flag, sent as header bit [7].
- HdrSpare  in  2  sent as header bits [5:4].
- NClus  in  4  number of clusters, sent as header bits [3:0].
- BadParity  in  1  inverts the transmitted parity bit (error injection).
- DataOut  out  1  serial data line, MSB first, registered.
- Busy  out  1  a packet is in progress.
- Done  out  1  one-cycle pulse at the end of a packet.
- Error  out  1  one-cycle pulse when a Start is rejected.

## Operation

- **Cluster RAM:** 16×12 words, plus a 16-entry parity shadow. Each ClusWr sets shadow[ClusAddr] = XOR of ClusData.
- **Start acceptance:** Start is accepted when Busy=0 and NClus ≤ MAXCLUS.
- **Latching:** On acceptance, the block latches Tag, ChipErr, HdrSpare, NClus and BadParity.
- **Parity bit P:** P = 1 ^ (XOR of the 10 other header bits after the start bit) ^ shadow[0] ^ … ^ shadow[NClus-1] ^ BadParity. Without BadParity, the XOR of all bits after the start bit is 1 (odd parity).
- **Rejected Start:** Start with Busy=1, or with NClus > MAXCLUS, pulses Error for one cycle. Nothing is latched and any frame in flight is unaffected.
- **Header word (12 bits, MSB first):** [11] start=1, [10] packet type=0, [9:8] Tag, [7] ChipErr, [6] P, [5:4] HdrSpare, [3:0] NClus.
- **States:**
  - IDLE: DataOut=0. Goes to HEAD on acceptance.
  - HEAD: 12 bits from a header shift register. Goes to CLUS if NClus>0, else to GAP.
  - CLUS: 12 bits per word. The RAM read address increments at each word boundary. Goes to GAP after word NClus-1.
  - GAP: GAP cycles of DataOut=0, then back to IDLE.
- **Counters:** a 4-bit bit counter (0..11) and a 4-bit word counter (0..NClus-1). Both wrap to 0 on exit.
- **RAM contents:** undefined after reset. The parity shadow clears to 0.

## Timing

- **Start accepted at edge of cycle T:**
  - DataOut = start bit in cycle T+1.
  - Header bits [10:0] in cycles T+2..T+12.
  - Cluster k, bit j (j=0 is bit 11) in cycle T+13+12k+j.
  - Zeros for GAP cycles after that.
- **End of packet:** Busy=1 in cycles T+1..T+12+12·NClus+GAP. In cycle E = T+13+12·NClus+GAP: Done=1 and Busy=0.
- **Back-to-back:** a Start in cycle E is accepted. Consecutive packets are therefore separated by GAP+1 zeros.
- **Error:** pulses in the cycle after the rejected Start.
- **Reset values:** DataOut=0, Busy=0, Done=0, Error=0, state IDLE.
- **Reset mid-frame:** the frame aborts, DataOut=0 from the next cycle, and no Done is issued.
- **Simultaneous Start and Reset:** Reset wins.
- **Simultaneous ClusWr and Start while idle:** the write completes first, and the parity calculation uses the new shadow value.

## Test plan

- **Zero clusters:** Tag=2, NClus=0, ChipErr=0, HdrSpare=0, BadParity=0. Expect DataOut T+1..T+12 = 1,0,1,0,0,0,0,0,0,0,0,0, then zeros. Done at T+15 with GAP=2.
- **Two clusters:** load addr0=0x041, addr1=0xFFF. Start with Tag=1, NClus=2. Expect header 1,0,0,1,0,1,0,0,0,0,1,0 (P=1), then 000001000001, then 111111111111. Done at T+39.
- **Parity injection:** repeat the two-cluster case with BadParity=1. Expect only header bit [6]=0 in cycle T+6; the rest of the frame is identical.
- **Start while Busy:** Start at T+5 of an active frame. Expect Error=1 at T+6 and the serial stream bit-identical to the undisturbed frame.
- **Overlimit:** NClus=11 with MAXCLUS=10. Expect Error pulse, DataOut stays 0, Busy stays 0.
- **Reset and back-to-back:**
  - Reset at T+20 of a 2-cluster frame: DataOut=0 from T+21, no Done, a new Start accepted at T+22.
  - Start held high continuously: exactly GAP+1 zeros between packets.

Source files
------------

// File: rtl/tkr_asic_data_tx.sv
// Emulates one pCT tracker front-end ASIC data output: on an accepted start it
// serialises a start bit, an 11-bit header and n_clus 12-bit cluster words,
// followed by a run of idle zeros.
module tkr_asic_data_tx #(
  parameter int unsigned MaxClus = 10,  // largest accepted cluster count (0..14)
  parameter int unsigned Gap     = 2    // idle zero bits after each packet (>= 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clus_wr_i,
  input  logic [3:0]  clus_addr_i,
  input  logic [11:0] clus_data_i,
  input  logic        start_i,
  input  logic [1:0]  tag_i,
  input  logic        chip_err_i,
  input  logic [1:0]  hdr_spare_i,
  input  logic [3:0]  n_clus_i,
  input  logic        bad_parity_i,
  output logic        data_out_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned     GapW     = (Gap > 1) ? $clog2(Gap) : 1;
  localparam logic [GapW-1:0] GapLast  = GapW'(Gap - 1);
  localparam logic [3:0]      MaxClusL = 4'(MaxClus);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHead = 2'd1;
  localparam logic [1:0] StClus = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  logic [11:0]     ram_q [16];
  logic [15:0]     shadow_q, shadow_d;
  logic [1:0]      state_q, state_d;
  logic [11:0]     shreg_q, shreg_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]      word_cnt_q, word_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]      n_clus_q, n_clus_d;
  logic            data_out_q, data_out_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic        idle;
  logic        wr_en;
  logic        accept;
  logic [15:0] clus_mask;
  logic        parity;
  logic [11:0] hdr_word;
  logic [3:0]  word_next;
  logic [3:0]  word_last;

  assign idle      = (state_q == StIdle);
  assign wr_en     = clus_wr_i && idle;
  assign accept    = start_i && idle && (n_clus_i <= MaxClusL);
  assign word_next = word_cnt_q + 4'd1;
  assign word_last = n_clus_q - 4'd1;

  // Parity shadow with this cycle's write applied, so a simultaneous write and
  // start see the new value.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) shadow_d[clus_addr_i] = ^clus_data_i;
  end

  // Header word with odd parity over everything after the start bit.
  always_comb begin
    clus_mask = 16'((17'd1 << n_clus_i) - 17'd1);
    parity    = ~(^{tag_i, chip_err_i, hdr_spare_i, n_clus_i})
                ^ (^(shadow_d & clus_mask)) ^ bad_parity_i;
    hdr_word  = {1'b1, 1'b0, tag_i, chip_err_i, parity, hdr_spare_i, n_clus_i};
  end

  // Next-state logic: data_out_d is the bit that will be on the line next cycle.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    n_clus_d   = n_clus_q;
    data_out_d = 1'b0;
    done_d     = 1'b0;
    error_d    = start_i && !accept;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StHead;
          data_out_d = hdr_word[11];
          shreg_d    = {hdr_word[10:0], 1'b0};
          bit_cnt_d  = 4'd0;
          n_clus_d   = n_clus_i;
        end
      end
      StHead: begin
        if (bit_cnt_q == 4'd11) begin
          bit_cnt_d = 4'd0;
          if (n_clus_q != 4'd0) begin
            state_d    = StClus;
            word_cnt_d = 4'd0;
            data_out_d = ram_q[0][11];
            shreg_d    = {ram_q[0][10:0], 1'b0};
          end else begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end
        end else begin
          data_out_d = shreg_q[11];
          shreg_d    = {shreg_q[10:0], 1'b0};
          bit_cnt_d  = bit_cnt_q + 4'd1;
        end
      end
      StClus: begin
        if (bit_cnt_q == 4'd11) begin
          bit_cnt_d = 4'd0;
          if (word_cnt_q == word_last) begin
            state_d    = StGap;
            word_cnt_d = 4'd0;
            gap_cnt_d  = '0;
          end else begin
            word_cnt_d = word_next;
            data_out_d = ram_q[word_next][11];
            shreg_d    = {ram_q[word_next][10:0], 1'b0};
          end
        end else begin
          data_out_d = shreg_q[11];
          shreg_d    = {shreg_q[10:0], 1'b0};
          bit_cnt_d  = bit_cnt_q + 4'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d   = StIdle;
          gap_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers; reset wins over any start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      n_clus_q   <= '0;
      shadow_q   <= '0;
      data_out_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      n_clus_q   <= n_clus_d;
      shadow_q   <= shadow_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Cluster RAM: contents are not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) ram_q[clus_addr_i] <= clus_data_i;
  end

  assign data_out_o = data_out_q;
  assign busy_o     = !idle;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule
